// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: bus widths, loader framing and state encoding.
// Imported by the loader, its interface and the memory-side blocks.
package cpu_pkg;

  localparam int         CPU_ADDR_W    = 8;
  localparam int         CPU_DATA_W    = 8;
  localparam logic [7:0] CPU_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } ldr_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus memory write port of the program loader.
// master = stream source / memory observer, slave = the loader itself.
interface prog_loader_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ena;
  logic              mem_write;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_ena,
    input  mem_write
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_addr,
    output mem_data,
    output mem_ena,
    output mem_write
  );

endinterface

// File: rtl/prog_loader_csum.sv
// Modular byte-sum accumulator; kept separate so a readback block can reuse it.
// Clear has priority over add.
module loader_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader (sync, len, payload, checksum).
// Writes payload to memory and holds the core in reset until a good frame lands.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = CPU_ADDR_W,
  parameter int                DATA_W    = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(CPU_SYNC_BYTE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         core_hold,
  output logic         done,
  output logic         err
);

  ldr_state_t        state, state_n;
  logic [DATA_W:0]   cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [DATA_W-1:0] wr_data, wr_data_n;
  logic              wr_ena, wr_ena_n;
  logic              rdy, rdy_n;
  logic              done_n, err_n, hold_n;
  logic              csum_clr, csum_add;
  logic [DATA_W-1:0] csum, total;
  logic              accept;

  assign accept = bus.in_valid && rdy;
  assign total  = csum + bus.in_data;

  loader_csum #(.W(DATA_W)) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .add (csum_add),
    .din (bus.in_data),
    .sum (csum)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = addr;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    wr_ena_n  = 1'b0;
    done_n    = done;
    err_n     = err;
    hold_n    = core_hold;
    csum_clr  = 1'b0;
    csum_add  = 1'b0;
    if (start) begin
      state_n = S_SYNC;
      done_n  = 1'b0;
      err_n   = 1'b0;
      hold_n  = 1'b1;
    end else if (accept) begin
      unique case (state)
        S_SYNC: begin
          if (bus.in_data == SYNC_BYTE) state_n = S_LEN;
        end
        S_LEN: begin
          // a zero length byte encodes a full 2^DATA_W payload
          cnt_n    = {(bus.in_data == '0), bus.in_data};
          addr_n   = LOAD_BASE;
          csum_clr = 1'b1;
          state_n  = S_DATA;
        end
        S_DATA: begin
          wr_ena_n  = 1'b1;
          wr_addr_n = addr;
          wr_data_n = bus.in_data;
          addr_n    = addr + 1'b1;
          csum_add  = 1'b1;
          cnt_n     = cnt - 1'b1;
          if (cnt == (DATA_W+1)'(1)) state_n = S_CSUM;
        end
        S_CSUM: begin
          if (total == '0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = S_ERR;
            err_n   = 1'b1;
            hold_n  = 1'b1;
          end
        end
        S_IDLE, S_DONE, S_ERR: ;
        default: ;
      endcase
    end
    rdy_n = state_n inside {S_SYNC, S_LEN, S_DATA, S_CSUM};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_ena    <= 1'b0;
      rdy       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      wr_ena    <= wr_ena_n;
      rdy       <= rdy_n;
      done      <= done_n;
      err       <= err_n;
      core_hold <= hold_n;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.mem_addr  = wr_addr;
  assign bus.mem_data  = wr_data;
  assign bus.mem_ena   = wr_ena;
  assign bus.mem_write = wr_ena;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (base 00 and FE) share one
// stream; expected writes are queued at send time and popped by a monitor.
module tb_prog_loader;
  import cpu_pkg::*;

  localparam logic [7:0] BASE_A = 8'h00;
  localparam logic [7:0] BASE_B = 8'hFE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       hold_a, done_a, err_a;
  logic       hold_b, done_b, err_b;

  int total = 0;
  int bad = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  junk[$];
  logic [7:0]  pl[$];

  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) ia ();
  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) ib ();

  assign ia.in_valid = in_valid;
  assign ia.in_data  = in_data;
  assign ib.in_valid = in_valid;
  assign ib.in_data  = in_data;

  prog_loader #(
    .ADDR_W(8), .DATA_W(8), .LOAD_BASE(BASE_A), .SYNC_BYTE(8'hA5)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .bus(ia),
    .core_hold(hold_a), .done(done_a), .err(err_a)
  );

  prog_loader #(
    .ADDR_W(8), .DATA_W(8), .LOAD_BASE(BASE_B), .SYNC_BYTE(8'hA5)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .bus(ib),
    .core_hold(hold_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    logic [15:0] e;
    if (ia.mem_ena === 1'b1) begin
      chk("a_wr_eq_ena", ia.mem_write, 1);
      chk("a_wr_vs_done", done_a, 0);
      chk("a_wr_pending", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_addr", ia.mem_addr, e[15:8]);
        chk("a_data", ia.mem_data, e[7:0]);
      end
    end
    if (ib.mem_ena === 1'b1) begin
      chk("b_wr_eq_ena", ib.mem_write, 1);
      chk("b_wr_vs_done", done_b, 0);
      chk("b_wr_pending", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_addr", ib.mem_addr, e[15:8]);
        chk("b_data", ib.mem_data, e[7:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    bit rdy;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      rdy      = ia.in_ready;
      @(posedge clk);
      ok = rdy;
    end
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic queue_write(input int idx, input logic [7:0] d);
    qa.push_back({8'((BASE_A + idx) % 256), d});
    qb.push_back({8'((BASE_B + idx) % 256), d});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_held(input string tag, input int rdy_exp);
    chk({tag, "_hold_a"}, hold_a, 1);
    chk({tag, "_hold_b"}, hold_b, 1);
    chk({tag, "_done_a"}, done_a, 0);
    chk({tag, "_err_a"}, err_a, 0);
    chk({tag, "_done_b"}, done_b, 0);
    chk({tag, "_rdy_a"}, ia.in_ready, rdy_exp);
  endtask

  // uses module-level junk/pl queues as the frame description
  task automatic send_frame(input logic [7:0] c, input bit gaps);
    int  s;
    bit  good;
    s = 0;
    foreach (junk[i]) send_byte(junk[i], gaps);
    send_byte(8'hA5, gaps);
    send_byte(pl.size() == 256 ? 8'h00 : 8'(pl.size()), gaps);
    foreach (pl[i]) begin
      queue_write(i, pl[i]);
      s += int'(pl[i]);
      send_byte(pl[i], gaps);
    end
    send_byte(c, gaps);
    @(negedge clk);
    in_valid = 1'b0;
    good = ((s + int'(c)) % 256) == 0;
    chk("done_a", done_a, int'(good));
    chk("err_a", err_a, int'(!good));
    chk("hold_a", hold_a, int'(!good));
    chk("done_b", done_b, int'(good));
    chk("err_b", err_b, int'(!good));
    chk("hold_b", hold_b, int'(!good));
    chk("rdy_end", ia.in_ready, 0);
  endtask

  function automatic logic [7:0] good_csum();
    int s;
    s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  function automatic logic [7:0] rnd_junk();
    logic [7:0] j;
    j = 8'($urandom_range(0, 255));
    return (j == 8'hA5) ? 8'h5A : j;
  endfunction

  initial begin
    logic [7:0] c;
    int         n;

    repeat (3) @(negedge clk);
    chk("rst_mem_ena", ia.mem_ena, 0);
    chk("rst_mem_write", ia.mem_write, 0);
    chk("rst_mem_addr", ia.mem_addr, 0);
    chk("rst_mem_data", ia.mem_data, 0);
    check_held("rst", 0);
    rst = 1'b0;

    // frame from the plan; sum 66 + 99 != 0 mod 256, so this is a bad frame
    pulse_start();
    chk("sync_rdy", ia.in_ready, 1);
    junk = {};
    pl = {8'h11, 8'h22, 8'h33};
    send_frame(8'h99, 1'b0);

    pulse_start();
    send_frame(8'h98, 1'b0);

    pulse_start();
    check_held("restart_err", 1);
    send_frame(8'h9A, 1'b0);

    pulse_start();
    junk = {8'h00, 8'hFF};
    pl = {8'h01, 8'h02};
    send_frame(8'hFD, 1'b0);

    for (int f = 0; f < 10; f++) begin
      pulse_start();
      junk = {};
      repeat ($urandom_range(0, 3)) junk.push_back(rnd_junk());
      pl = {};
      n = $urandom_range(1, 24);
      repeat (n) pl.push_back(8'($urandom_range(0, 255)));
      c = good_csum();
      if (f % 3 == 1) c = c ^ 8'($urandom_range(1, 255));
      send_frame(c, 1'b1);
    end

    pulse_start();
    junk = {};
    pl = {};
    repeat (256) pl.push_back(8'($urandom_range(0, 255)));
    send_frame(good_csum(), 1'b0);

    // restart from DONE
    pulse_start();
    check_held("restart_done", 1);

    // restart mid-payload with a byte on the bus: that byte is dropped
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 2; i++) begin
      c = 8'($urandom_range(0, 255));
      queue_write(i, c);
      send_byte(c, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h77;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check_held("restart_data", 1);
    junk = {};
    pl = {8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(good_csum(), 1'b0);

    // reset mid-payload: no writes beyond the accepted bytes
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      c = 8'($urandom_range(0, 255));
      queue_write(i, c);
      send_byte(c, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_held("mid_rst", 0);
    chk("mid_rst_ena", ia.mem_ena, 0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_rdy", ia.in_ready, 0);

    repeat (4) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
